// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM encodings, register-zero index and
// the bundle of pipeline control enables driven by the hazard controller.
package hazard_stall_ctrl_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LOADUSE = 2'd1;
  localparam logic [1:0] ST_MEMWAIT = 2'd2;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_BRANCH  = 2'd1,
    CAUSE_LOADUSE = 2'd2,
    CAUSE_MEM     = 2'd3
  } hazard_cause_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_stall;
    logic idex_bubble;
    logic exmem_stall;
  } ctrl_t;

  localparam ctrl_t CTRL_ADVANCE = '{pc_write: 1'b1, ifid_write: 1'b1, default: 1'b0};

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == CNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side hazard bus: ID/EX source fields and events in, stage enables out.
interface hazard_stall_ctrl_if;
  logic [4:0]  ID_RSaddr_i;
  logic [4:0]  ID_RTaddr_i;
  logic        ID_usesRT_i;
  logic        EX_MemRead_i;
  logic [4:0]  EX_RTaddr_i;
  logic        branch_taken_i;
  logic        mem_stall_i;
  logic        PC_write_o;
  logic        IFID_write_o;
  logic        IFID_flush_o;
  logic        IDEX_stall_o;
  logic        IDEX_bubble_o;
  logic        EXMEM_stall_o;
  logic [15:0] stall_count_o;
  logic [1:0]  state_o;

  modport master (
    output ID_RSaddr_i, ID_RTaddr_i, ID_usesRT_i, EX_MemRead_i, EX_RTaddr_i,
           branch_taken_i, mem_stall_i,
    input  PC_write_o, IFID_write_o, IFID_flush_o, IDEX_stall_o, IDEX_bubble_o,
           EXMEM_stall_o, stall_count_o, state_o
  );

  modport slave (
    input  ID_RSaddr_i, ID_RTaddr_i, ID_usesRT_i, EX_MemRead_i, EX_RTaddr_i,
           branch_taken_i, mem_stall_i,
    output PC_write_o, IFID_write_o, IFID_flush_o, IDEX_stall_o, IDEX_bubble_o,
           EXMEM_stall_o, stall_count_o, state_o
  );
endinterface

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Load-use detector: the load in EX targets a register the ID instruction reads.
module load_use_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic       i_mem_read,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  output logic       o_loaduse
);

  logic w_rs_match;
  logic w_rt_match;

  // Register zero is hard-wired, so a load into it never creates a dependency.
  assign w_rs_match = (i_ex_rt == i_id_rs);
  assign w_rt_match = i_id_uses_rt && (i_ex_rt == i_id_rt);
  assign o_loaduse  = i_mem_read && (i_ex_rt != REG_ZERO) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard stall controller: combinational stage enables from the highest-priority
// hazard, with registered state reporting and a saturating stall-cycle counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  hazard_stall_ctrl_if.slave   hz
);

  logic          w_loaduse;
  hazard_cause_e w_cause;
  ctrl_t         w_ctrl;
  logic [1:0]    w_state_next;
  logic [1:0]    r_state;
  logic [15:0]   r_stall_count;

  load_use_detect u_load_use_detect (
    .i_mem_read   (hz.EX_MemRead_i),
    .i_ex_rt      (hz.EX_RTaddr_i),
    .i_id_rs      (hz.ID_RSaddr_i),
    .i_id_rt      (hz.ID_RTaddr_i),
    .i_id_uses_rt (hz.ID_usesRT_i),
    .o_loaduse    (w_loaduse)
  );

  // A pending memory stall hides everything; a load-use bubble hides a branch,
  // which is simply seen again once the bubble has gone through.
  always_comb begin
    w_cause = CAUSE_NONE;
    if (hz.mem_stall_i) begin
      w_cause = CAUSE_MEM;
    end else if (w_loaduse) begin
      w_cause = CAUSE_LOADUSE;
    end else if (hz.branch_taken_i) begin
      w_cause = CAUSE_BRANCH;
    end
  end

  // Every state reacts to the inputs alike; the state register only records
  // which hazard is being serviced, and the unused code 3 behaves as RUN.
  always_comb begin
    w_ctrl       = CTRL_ADVANCE;
    w_state_next = ST_RUN;
    if (rst_i) begin
      case (w_cause)
        CAUSE_MEM: begin
          w_ctrl.pc_write    = 1'b0;
          w_ctrl.ifid_write  = 1'b0;
          w_ctrl.idex_stall  = 1'b1;
          w_ctrl.exmem_stall = 1'b1;
          w_state_next       = ST_MEMWAIT;
        end
        CAUSE_LOADUSE: begin
          w_ctrl.pc_write    = 1'b0;
          w_ctrl.ifid_write  = 1'b0;
          w_ctrl.idex_bubble = 1'b1;
          w_state_next       = ST_LOADUSE;
        end
        CAUSE_BRANCH: begin
          w_ctrl.ifid_flush  = 1'b1;
        end
        default: begin
          w_ctrl = CTRL_ADVANCE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state       <= ST_RUN;
      r_stall_count <= 16'd0;
    end else begin
      r_state <= w_state_next;
      if (!w_ctrl.pc_write) begin
        r_stall_count <= sat_inc16(r_stall_count);
      end
    end
  end

  assign hz.PC_write_o    = w_ctrl.pc_write;
  assign hz.IFID_write_o  = w_ctrl.ifid_write;
  assign hz.IFID_flush_o  = w_ctrl.ifid_flush;
  assign hz.IDEX_stall_o  = w_ctrl.idex_stall;
  assign hz.IDEX_bubble_o = w_ctrl.idex_bubble;
  assign hz.EXMEM_stall_o = w_ctrl.exmem_stall;
  assign hz.stall_count_o = r_stall_count;
  assign hz.state_o       = r_state;

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_i, input, 1; reset is synchronous and active-low.
REQ-003 SHALL have port ID_RSaddr_i, input, 5, rs field of the instruction in ID.
REQ-004 SHALL have port ID_RTaddr_i, input, 5, rt field of the instruction in ID.
REQ-005 SHALL have port ID_usesRT_i, input, 1, high when the ID instruction reads rt as a source.
REQ-006 SHALL have port EX_MemRead_i, input, 1, Memory_read held in the ID/EX register.
REQ-007 SHALL have port EX_RTaddr_i, input, 5, RTaddr held in the ID/EX register.
REQ-008 SHALL have port branch_taken_i, input, 1, branch resolved taken in ID.
REQ-009 SHALL have port mem_stall_i, input, 1, data memory not ready this cycle.
REQ-010 SHALL have port PC_write_o, output, 1, PC update enable.
REQ-011 SHALL have port IFID_write_o, output, 1, IF/ID register write enable.
REQ-012 SHALL have port IFID_flush_o, output, 1, IF/ID register clear to NOP.
REQ-013 SHALL have port IDEX_stall_o, output, 1, drives stall_i of the ID/EX register (hold).
REQ-014 SHALL have port IDEX_bubble_o, output, 1, forces all control bits entering ID/EX to 0.
REQ-015 SHALL have port EXMEM_stall_o, output, 1, hold for EX/MEM and MEM/WB registers.
REQ-016 SHALL have port stall_count_o, output, 16, count of cycles with PC_write_o low.
REQ-017 SHALL have port state_o, output, 2, current FSM state encoding.

Function
REQ-018 SHALL implement FSM states RUN=2'd0, LOADUSE=2'd1, MEMWAIT=2'd2; 2'd3 SHALL be treated as RUN.
REQ-019 SHALL compute outputs combinationally from current state and inputs (zero-cycle response); state and counter are registered.
REQ-020 SHALL define loaduse = EX_MemRead_i && EX_RTaddr_i!=0 && (EX_RTaddr_i==ID_RSaddr_i || (ID_usesRT_i && EX_RTaddr_i==ID_RTaddr_i)).
REQ-021 SHALL give priority mem_stall_i > loaduse > branch_taken_i, evaluated in every state.
REQ-022 When mem_stall_i=1: PC_write_o=0, IFID_write_o=0, IDEX_stall_o=1, EXMEM_stall_o=1, IDEX_bubble_o=0, IFID_flush_o=0; next state MEMWAIT.
REQ-023 When mem_stall_i=0 and loaduse=1: PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1, IDEX_stall_o=0, IFID_flush_o=0; next state LOADUSE.
REQ-024 When mem_stall_i=0, loaduse=0 and branch_taken_i=1: IFID_flush_o=1, PC_write_o=1; next state RUN.
REQ-025 Otherwise: PC_write_o=1, IFID_write_o=1, all other control outputs 0; next state RUN.
REQ-026 Branch coinciding with loaduse SHALL be suppressed that cycle and is re-evaluated after the bubble.
REQ-027 MEMWAIT SHALL persist exactly while mem_stall_i=1 and exit to RUN on the first cycle it is low.
REQ-028 stall_count_o SHALL increment by 1 each cycle PC_write_o=0 and saturate at 16'hFFFF.

Reset
REQ-029 On a rising edge with rst_i=0: state SHALL become RUN and stall_count_o 0, regardless of the current state (including MEMWAIT).
REQ-030 While rst_i=0: outputs SHALL be PC_write_o=1, IFID_write_o=1, all other 1-bit outputs 0, independent of the other inputs.

Structure
REQ-031 SHALL place the state encodings and REG_ZERO=5'd0 in the shared pipeline package.
REQ-032 SHALL instantiate one combinational sub-module, load_use_detect, computing loaduse per REQ-020.

Verification
REQ-033 EX_MemRead_i=1, EX_RTaddr_i=8, ID_RSaddr_i=8 -> same cycle PC_write_o=0, IDEX_bubble_o=1; next cycle state_o=1; stall_count_o=1.
REQ-034 EX_MemRead_i=1, EX_RTaddr_i=0, ID_RSaddr_i=0 -> no stall, state_o stays 0.
REQ-035 mem_stall_i high 3 cycles -> 3 cycles with IDEX_stall_o=EXMEM_stall_o=1 and state_o=2; stall_count_o=3; RUN on the 4th cycle.
REQ-036 branch_taken_i=1 with loaduse true -> IFID_flush_o=0, bubble; next cycle loaduse false and branch_taken_i=1 -> IFID_flush_o=1.
REQ-037 rst_i=0 during MEMWAIT with mem_stall_i=1 -> PC_write_o=1 immediately; after the edge state_o=0 and stall_count_o=0.
REQ-038 Counter preset near 16'hFFFF, 2 stall cycles -> stall_count_o holds at 16'hFFFF.
